// File: rtl/gate_chk_pkg.sv
// Shared definitions for the gate truth checker: FSM state encoding and
// the vector-count helper used to size the truth-table ports.
package gate_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Number of input vectors for an n-input gate.
  function automatic int vec_count(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/gtc_settle_timer.sv
// Settle down-counter for the gate truth checker. Loads a count, decrements
// to zero and then holds; expired is high while the count is zero.
module gtc_settle_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic       expired
);

  logic [3:0] count;

  // Load on request, otherwise count down and stop at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 4'd0;
    end else if (load) begin
      count <= load_val;
    end else if (count != 4'd0) begin
      count <= count - 4'd1;
    end
  end

  assign expired = (count == 4'd0);

endmodule

// File: rtl/gate_truth_checker.sv
// Gate truth checker: sweeps every input vector into a gate under test,
// waits SETTLE cycles per vector, samples the gate output and compares it
// with a snapshot of the expected truth table.
// Optional build macro GTC_STOP_ON_FAIL_EN: end the sweep at the first
// mismatching vector instead of running all vectors.
module gate_truth_checker
  import gate_chk_pkg::*;
#(
  parameter int N_IN   = 2,
  parameter int SETTLE = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [vec_count(N_IN)-1:0] exp_table,
  output logic [N_IN-1:0]            dut_in,
  input  logic                       dut_out,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic [N_IN:0]              err_cnt,
  output logic [vec_count(N_IN)-1:0] fail_vec
);

  localparam int              V           = vec_count(N_IN);
  localparam logic [N_IN-1:0] LAST_VEC    = N_IN'(V - 1);
  localparam logic [N_IN:0]   ERR_MAX     = (N_IN + 1)'(V);
  localparam logic [3:0]      SETTLE_LOAD = 4'(SETTLE - 1);

  state_t         state;
  state_t         state_next;
  logic [V-1:0]   exp_snap;
  logic           timer_load;
  logic           timer_expired;
  logic           mismatch;
  logic           sweep_end;

  gtc_settle_timer u_settle_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (SETTLE_LOAD),
    .expired  (timer_expired)
  );

  assign mismatch = (dut_out != exp_snap[dut_in]);

`ifdef GTC_STOP_ON_FAIL_EN
  assign sweep_end = (dut_in == LAST_VEC) || mismatch;
`else
  assign sweep_end = (dut_in == LAST_VEC);
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic, timer reload and the busy/done status outputs.
  always_comb begin
    state_next = state;
    timer_load = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_SETTLE;
          timer_load = 1'b1;
        end
      end
      ST_SETTLE: begin
        busy = 1'b1;
        if (timer_expired) begin
          state_next = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        busy = 1'b1;
        if (sweep_end) begin
          state_next = ST_DONE;
        end else begin
          state_next = ST_SETTLE;
          timer_load = 1'b1;
        end
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Sweep datapath: table snapshot, vector counter and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_snap <= '0;
      dut_in   <= '0;
      err_cnt  <= '0;
      fail_vec <= '0;
      pass     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            exp_snap <= exp_table;
            dut_in   <= '0;
            err_cnt  <= '0;
            fail_vec <= '0;
            pass     <= 1'b0;
          end
        end
        ST_SAMPLE: begin
          if (mismatch) begin
            fail_vec[dut_in] <= 1'b1;
            if (err_cnt != ERR_MAX) begin
              err_cnt <= err_cnt + 1'b1;
            end
          end
          if (!sweep_end) begin
            dut_in <= dut_in + 1'b1;
          end
        end
        ST_DONE: begin
          pass <= (err_cnt == '0);
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_truth_checker.sv
// Scoreboard bench for gate_truth_checker: a table-driven gate model feeds
// dut_out, stimulus pushes expected sweep results, a monitor checks the
// per-cycle sweep timeline and the final results.
module tb_gate_truth_checker;

  localparam int N_IN   = 2;
  localparam int SETTLE = 2;
  localparam int V      = 1 << N_IN;
  localparam int PER    = SETTLE + 1;

  logic            clk       = 1'b0;
  logic            rst_n     = 1'b1;
  logic            start     = 1'b0;
  logic [V-1:0]    exp_table = '0;
  logic [V-1:0]    gut_table = '0;
  logic [N_IN-1:0] dut_in;
  logic            dut_out;
  logic            busy;
  logic            done;
  logic            pass;
  logic [N_IN:0]   err_cnt;
  logic [V-1:0]    fail_vec;

  typedef struct {
    logic [V-1:0] fail;
    int           err;
    logic         pass;
  } exp_t;

  exp_t sb_q[$];
  exp_t cur;
  int   checks      = 0;
  int   failures    = 0;
  int   cyc         = 0;
  bit   sweep_active = 1'b0;
  bit   result_due   = 1'b0;
  int   sweep_k      = 0;
  int   sweep_len    = 0;
  int   sweep_last   = 0;

  gate_truth_checker #(.N_IN(N_IN), .SETTLE(SETTLE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .exp_table (exp_table),
    .dut_in    (dut_in),
    .dut_out   (dut_out),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_cnt   (err_cnt),
    .fail_vec  (fail_vec)
  );

  // Gate under test modelled as a lookup table indexed by its inputs.
  assign dut_out = gut_table[dut_in];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: result of sweeping gate table g against expected table e.
  task automatic model(input logic [V-1:0] g, input logic [V-1:0] e,
                       output exp_t r, output int len, output int last);
    logic [V-1:0] diff;
    diff   = g ^ e;
    r.fail = diff;
    r.err  = 0;
    for (int i = 0; i < V; i++) if (diff[i]) r.err++;
    len  = V * PER;
    last = V - 1;
`ifdef GTC_STOP_ON_FAIL_EN
    if (diff != '0) begin
      int idx;
      idx = 0;
      for (int i = V - 1; i >= 0; i--) if (diff[i]) idx = i;
      r.fail      = '0;
      r.fail[idx] = 1'b1;
      r.err       = 1;
      last        = idx;
      len         = (idx + 1) * PER;
    end
`endif
    r.pass = (r.err == 0);
  endtask

  // Issue one sweep; extra_at > 0 re-pulses start so it is sampled at edge
  // k+extra_at, and -1 places the extra pulse on the DONE-state edge.
  task automatic applyStimulus(input logic [V-1:0] g, input logic [V-1:0] e, input int extra_at);
    exp_t r;
    int   len;
    int   last;
    int   xat;
    model(g, e, r, len, last);
    @(posedge clk); #2;
    gut_table    = g;
    exp_table    = e;
    start        = 1'b1;
    sb_q.push_back(r);
    sweep_k      = cyc + 1;
    sweep_len    = len;
    sweep_last   = last;
    result_due   = 1'b0;
    sweep_active = 1'b1;
    @(posedge clk); #2;
    start     = 1'b0;
    exp_table = V'($urandom);
    xat = (extra_at == -1) ? len + 1 : extra_at;
    if (xat > 0) begin
      repeat (xat - 1) @(posedge clk);
      #2 start = 1'b1;
      @(posedge clk); #2;
      start = 1'b0;
    end
    for (int i = 0; i < len + 20 && sweep_active; i++) @(posedge clk);
    if (sweep_active) begin
      checks++;
      failures++;
      $display("[TB] FAIL sweep_timeout actual=no_result required=result");
      sweep_active = 1'b0;
      sb_q.delete();
    end
    repeat (2) @(posedge clk);
  endtask

  // Start a sweep with a matching gate, reset it during the second settle.
  task automatic resetMidSweep(input logic [V-1:0] g);
    @(posedge clk); #2;
    gut_table = g;
    exp_table = g;
    start     = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (PER + 1) @(posedge clk);
    #2;
    check("pre_reset_busy", busy, 1);
    check("pre_reset_dut_in", dut_in, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_reset");
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic checkOutput(input string tag);
    check({tag, "_dut_in"}, dut_in, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pass"}, pass, 0);
    check({tag, "_err_cnt"}, err_cnt, 0);
    check({tag, "_fail_vec"}, fail_vec, 0);
  endtask

  // Monitor: per-cycle timeline checks and result comparison after done.
  initial begin
    forever begin
      @(negedge clk);
      if (sweep_active && cyc >= sweep_k) begin
        int j;
        j = (cyc - sweep_k) / PER;
        if (j > sweep_last) j = sweep_last;
        check("dut_in", dut_in, j);
        check("busy", busy, (cyc < sweep_k + sweep_len) ? 1 : 0);
        check("done", done, (cyc == sweep_k + sweep_len) ? 1 : 0);
        if (cyc == sweep_k + sweep_len) begin
          if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL scoreboard_empty actual=done required=queued_entry");
          end else begin
            cur        = sb_q.pop_front();
            result_due = 1'b1;
          end
        end else if (result_due && cyc == sweep_k + sweep_len + 1) begin
          check("err_cnt", err_cnt, cur.err);
          check("fail_vec", fail_vec, cur.fail);
          check("pass", pass, cur.pass);
          result_due   = 1'b0;
          sweep_active = 1'b0;
        end
      end else if (rst_n) begin
        check("idle_done", done, 0);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [V-1:0] g;
    logic [V-1:0] e;
    #1 rst_n = 1'b0;
    #3;
    checkOutput("reset");
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    applyStimulus(4'b0000, 4'b1000, 0);
    applyStimulus(4'b0111, 4'b1000, 0);
    applyStimulus(4'b1000, 4'b1000, 3);
    applyStimulus(4'b1110, 4'b1110, -1);
    applyStimulus(4'b1111, 4'b1000, 0);
    applyStimulus(4'b1000, 4'b1000, 0);
    resetMidSweep(4'b0110);
    applyStimulus(4'b0110, 4'b0110, 0);
    applyStimulus(4'b0110, 4'b1001, 0);

    for (int n = 0; n < 20; n++) begin
      g = V'($urandom);
      e = ($urandom_range(0, 3) == 0) ? g : V'($urandom);
      applyStimulus(g, e, $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gate_truth_checker.md
Name: gate_truth_checker

Overview:
- Self-checking sequencer for the basic-gates-from-demux/decoder blocks, such as the NOT, AND and OR decoder gates.
- Sits both directly upstream and downstream of the gate under test (GUT):
  - drives every input combination into the GUT;
  - waits a settle time;
  - samples the single-bit GUT output and compares it to an expected truth table.
- Reports pass/fail, an error count and a bitmap of failing input vectors. Replaces hand-written delay-only stimulus with a clocked, repeatable check.

Parameters:
- N_IN, 2, number of GUT inputs; legal range 1..4; vector count V = 2**N_IN.
- SETTLE, 2, clock cycles dut_in is held before sampling; legal range 1..15.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to run a full sweep; honoured only in IDLE.
- exp_table  in  V  expected output per vector; bit i = expected dut_out when dut_in == i. Captured on the accepted start.
- dut_in  out  N_IN  registered input vector driven to the GUT.
- dut_out  in  1  GUT output, combinational from dut_in.
- busy  out  1  high from the cycle after an accepted start through the last SAMPLE cycle.
- done  out  1  one-cycle pulse when the sweep ends.
- pass  out  1  high when err_cnt == 0 at the end of the sweep; held until the next accepted start.
- err_cnt  out  N_IN+1  number of mismatching vectors; saturates at V.
- fail_vec  out  V  bit i set when vector i mismatched.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on rst_n. Asserting rst_n low at any time, including mid-sweep, forces the following state immediately:
  - state = IDLE;
  - dut_in = 0, busy = 0, done = 0, pass = 0;
  - err_cnt = 0, fail_vec = 0;
  - settle counter = 0, exp snapshot = 0.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - start = 1 → capture exp_table into exp_snap, set dut_in = 0, clear err_cnt, fail_vec and pass, load settle counter = SETTLE-1, go to SETTLE.
  - start = 0 → stay in IDLE; outputs hold their last values.
- SETTLE:
  - busy = 1.
  - Counter = 0 → go to SAMPLE; otherwise decrement.
  - dut_in is stable throughout.
- SAMPLE:
  - busy = 1.
  - Compare dut_out against exp_snap[dut_in]. On mismatch, set fail_vec[dut_in] and increment err_cnt.
  - dut_in == V-1 → go to DONE.
  - Otherwise dut_in += 1, reload counter = SETTLE-1, go to SETTLE.
- DONE:
  - done = 1 for exactly this cycle, busy = 0.
  - pass <= (err_cnt == 0), where err_cnt includes any final-vector increment.
  - Go to IDLE.
- Latency: start accepted at edge k → done high in the cycle after edge k + V*(SETTLE+1).
  - Example: N_IN = 1, SETTLE = 2 → edge k + 6, i.e. done visible during the 7th cycle after start.
- start while busy or in DONE: ignored, with no restart and no effect on results.
- exp_table changes mid-sweep: no effect; only the snapshot is used.
- dut_in wrap: never wraps; the sweep ends at V-1, and dut_in holds V-1 until the next start.
- err_cnt cannot overflow: its width holds V, and the increment is guarded by saturation.
- dut_out is sampled only in SAMPLE; glitches during SETTLE are irrelevant.

Optional Feature:
- Macro: GTC_STOP_ON_FAIL_EN.
- Defined: a mismatch in SAMPLE goes directly to DONE after recording it. err_cnt = 1, fail_vec holds the single failing bit, pass = 0, and dut_in holds the failing vector.
- Undefined: the full sweep always runs, as described in Behaviour.

Decomposition:
- Package gate_chk_pkg: state encoding localparams (IDLE = 2'd0, SETTLE = 2'd1, SAMPLE = 2'd2, DONE = 2'd3) and the helper constant function vec_count(n) = 1 << n.
- One sub-module, gtc_settle_timer:
  - ports: clk, rst_n, load, load_val[3:0], expired;
  - down-counter with asynchronous reset to 0;
  - expired = (count == 0).
- FSM, result registers and the comparator stay in gate_truth_checker.

Test Plan:
- NOT-gate GUT, N_IN = 1, SETTLE = 2, exp_table = 2'b01, pulse start → done 7 cycles later, pass = 1, err_cnt = 0, fail_vec = 2'b00; dut_in sequence 0, 0, 0, 1, 1, 1.
- Stuck-at-0 GUT (dut_out = 0), N_IN = 2, exp_table = 4'b1000 (AND) → pass = 0, err_cnt = 1, fail_vec = 4'b1000.
- Inverted GUT vs AND table, N_IN = 2 → err_cnt = 4, fail_vec = 4'b1111, pass = 0.
- Pulse start again 3 cycles after the first accepted start → no restart; a single done at the original cycle count.
- Assert rst_n low during the second SETTLE of a sweep → all outputs 0 immediately. A new start after release runs a clean full sweep and gives the correct result.
- GTC_STOP_ON_FAIL_EN defined, stuck-at-1 GUT, exp_table = 4'b1000 → done after the first SAMPLE (3 cycles at SETTLE = 2), err_cnt = 1, fail_vec = 4'b0001, dut_in = 0.
